// File: rtl/fifo_lane_dispatch_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_lane_dispatch_merge
// Brief    : Round-robin split of one stream onto two lanes, with in-order
//            merge of the lane responses through a lane-tag order FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_lane_dispatch_merge #(
  parameter int DW          = 32,
  parameter int ORDER_DEPTH = 8,
  parameter int CW          = $clog2(ORDER_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m0_valid,
  input  logic          m0_ready,
  output logic [DW-1:0] m0_data,
  output logic          m1_valid,
  input  logic          m1_ready,
  output logic [DW-1:0] m1_data,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [DW-1:0] r0_data,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [DW-1:0] r1_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] outstanding
);

  localparam int c_AW = $clog2(ORDER_DEPTH);

  logic                   r_sel;
  logic                   r_m0_valid;
  logic                   r_m1_valid;
  logic [DW-1:0]          r_m0_data;
  logic [DW-1:0]          r_m1_data;
  logic                   r_out_valid;
  logic [DW-1:0]          r_out_data;
  logic [ORDER_DEPTH-1:0] r_tag;
  logic [CW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_lane_free;
  logic w_push;
  logic w_head;
  logic w_out_free;
  logic w_r0_fire;
  logic w_r1_fire;
  logic w_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_lane_free = r_sel ? (!r_m1_valid || m1_ready) : (!r_m0_valid || m0_ready);
  assign s_ready     = !w_full && w_lane_free;
  assign w_push      = s_valid && s_ready;

  assign w_head      = r_tag[r_rd_ptr[c_AW-1:0]];
  assign w_out_free  = !r_out_valid || out_ready;
  assign r0_ready    = !w_head && !w_empty && w_out_free;
  assign r1_ready    =  w_head && !w_empty && w_out_free;
  assign w_r0_fire   = r0_valid && r0_ready;
  assign w_r1_fire   = r1_valid && r1_ready;
  assign w_pop       = w_r0_fire || w_r1_fire;

  assign m0_valid    = r_m0_valid;
  assign m0_data     = r_m0_data;
  assign m1_valid    = r_m1_valid;
  assign m1_data     = r_m1_data;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign outstanding = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel      <= 1'b0;
      r_m0_valid <= 1'b0;
      r_m1_valid <= 1'b0;
      r_m0_data  <= '0;
      r_m1_data  <= '0;
    end else begin
      if (r_m0_valid && m0_ready) r_m0_valid <= 1'b0;
      if (r_m1_valid && m1_ready) r_m1_valid <= 1'b0;
      if (w_push) begin
        r_sel <= !r_sel;
        if (r_sel) begin
          r_m1_valid <= 1'b1;
          r_m1_data  <= s_data;
        end else begin
          r_m0_valid <= 1'b1;
          r_m0_data  <= s_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tag    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr[c_AW-1:0]] <= r_sel;
        r_wr_ptr                  <= r_wr_ptr + CW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_r1_fire ? r1_data : r0_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_lane_dispatch_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_lane_dispatch_merge
// Brief    : Self-checking bench with lane loopback models and an in-order
//            scoreboard for fifo_lane_dispatch_merge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_lane_dispatch_merge;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m0_valid, m1_valid;
  logic          m0_ready = 1'b1, m1_ready = 1'b1;
  logic [DW-1:0] m0_data, m1_data;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic          r0_ready, r1_ready;
  logic [DW-1:0] r0_data = '0, r1_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [CW-1:0] outstanding;

  always #5 clk = ~clk;

  fifo_lane_dispatch_merge #(.DW(DW), .ORDER_DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .outstanding(outstanding)
  );

  typedef struct { logic [DW-1:0] d; int t; } resp_t;
  typedef struct { int lane; logic [DW-1:0] d; } mlog_t;
  typedef struct { logic [DW-1:0] data; int lane; logic [DW-1:0] exp_out; } vec_t;

  logic [DW-1:0] src[$], exp_out[$], exp_l0[$], exp_l1[$], out_log[$];
  resp_t         lq0[$], lq1[$];
  mlog_t         m_log[$];

  int   n_checks = 0, n_errors = 0, cyc = 0, mcnt = 0;
  int   dly0 = 0, dly1 = 0, out_mode = 0;
  logic msel = 1'b0;
  logic f_s = 1'b0, f_m0 = 1'b0, f_m1 = 1'b0, f_r0 = 1'b0, f_r1 = 1'b0, f_out = 1'b0;
  logic stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic m0_rdy_en = 1'b1, m1_rdy_en = 1'b1, resp_en0 = 1'b1, resp_en1 = 1'b1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not expected by the model (t=%0t)", name, $time);
  endtask

  // Inputs change just after the rising edge; valids are held until they transfer.
  task automatic drive();
    if (!(s_valid && !f_s)) begin
      if (src.size() > 0) begin s_valid = 1'b1; s_data = src.pop_front(); end
      else s_valid = 1'b0;
    end
    if (!(r0_valid && !f_r0)) begin
      if (resp_en0 && lq0.size() > 0 && lq0[0].t <= cyc) begin r0_valid = 1'b1; r0_data = lq0[0].d; end
      else r0_valid = 1'b0;
    end
    if (!(r1_valid && !f_r1)) begin
      if (resp_en1 && lq1.size() > 0 && lq1[0].t <= cyc) begin r1_valid = 1'b1; r1_data = lq1[0].d; end
      else r1_valid = 1'b0;
    end
    m0_ready = m0_rdy_en;
    m1_ready = m1_rdy_en;
    case (out_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = 1'b0;
    endcase
  endtask

  // Evaluated late in the cycle: decides which transfers happen at the next edge.
  task automatic eval();
    resp_t r;
    mlog_t ml;
    f_s   = s_valid && s_ready;
    f_m0  = m0_valid && m0_ready;
    f_m1  = m1_valid && m1_ready;
    f_r0  = r0_valid && r0_ready;
    f_r1  = r1_valid && r1_ready;
    f_out = out_valid && out_ready;
    check("outstanding", DW'(outstanding), DW'(mcnt));
    if (stall_pend) begin
      check("out_valid_hold", DW'(out_valid), DW'(1));
      check("out_data_hold", out_data, stall_data);
    end
    if (f_s) begin
      exp_out.push_back(s_data);
      if (msel) exp_l1.push_back(s_data);
      else      exp_l0.push_back(s_data);
      msel = !msel;
    end
    if (f_m0) begin
      if (exp_l0.size() == 0) fail("m0_spurious");
      else check("m0_data", m0_data, exp_l0.pop_front());
      r.d = m0_data; r.t = cyc + 1 + dly0; lq0.push_back(r);
      ml.lane = 0; ml.d = m0_data; m_log.push_back(ml);
    end
    if (f_m1) begin
      if (exp_l1.size() == 0) fail("m1_spurious");
      else check("m1_data", m1_data, exp_l1.pop_front());
      r.d = m1_data; r.t = cyc + 1 + dly1; lq1.push_back(r);
      ml.lane = 1; ml.d = m1_data; m_log.push_back(ml);
    end
    if (f_out) begin
      if (exp_out.size() == 0) fail("out_spurious");
      else check("out_data", out_data, exp_out.pop_front());
      out_log.push_back(out_data);
    end
    stall_pend = out_valid && !out_ready;
    stall_data = out_data;
    if (f_r0) lq0.delete(0);
    if (f_r1) lq1.delete(0);
    mcnt = mcnt + int'(f_s) - int'(f_r0 || f_r1);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1 drive();
    #3 eval();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((src.size() > 0 || exp_out.size() > 0 || s_valid || out_valid) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) fail("drain_timeout");
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic apply_reset();
    rstn = 1'b0;
    #1;
    check("rst_m0_valid", DW'(m0_valid), DW'(0));
    check("rst_m1_valid", DW'(m1_valid), DW'(0));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_outstanding", DW'(outstanding), DW'(0));
    check("rst_m0_data", m0_data, '0);
    check("rst_m1_data", m1_data, '0);
    check("rst_out_data", out_data, '0);
    src.delete(); exp_out.delete(); exp_l0.delete(); exp_l1.delete();
    lq0.delete(); lq1.delete(); m_log.delete(); out_log.delete();
    msel = 1'b0; mcnt = 0; stall_pend = 1'b0;
    f_s = 1'b0; f_m0 = 1'b0; f_m1 = 1'b0; f_r0 = 1'b0; f_r1 = 1'b0; f_out = 1'b0;
    s_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; out_mode = 0;
    @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[4];
    int   n_blk;
    vec[0] = '{data: 32'h11, lane: 0, exp_out: 32'h11};
    vec[1] = '{data: 32'h22, lane: 1, exp_out: 32'h22};
    vec[2] = '{data: 32'h33, lane: 0, exp_out: 32'h33};
    vec[3] = '{data: 32'h44, lane: 1, exp_out: 32'h44};

    #2 apply_reset();
    #1 check("rst_s_ready", DW'(s_ready), DW'(1));

    // Basic round-robin dispatch and in-order merge.
    foreach (vec[i]) src.push_back(vec[i].data);
    drain(60);
    check("t1_mlog_count", DW'(m_log.size()), DW'(4));
    check("t1_out_count", DW'(out_log.size()), DW'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < m_log.size()) begin
        check("t1_lane", DW'(m_log[i].lane), DW'(vec[i].lane));
        check("t1_lane_data", m_log[i].d, vec[i].data);
      end
      if (i < out_log.size()) check("t1_out_order", out_log[i], vec[i].exp_out);
    end
    check("t1_outstanding_end", DW'(outstanding), DW'(0));

    // Lane 1 answers well before lane 0: it must wait for the head.
    dly0 = 6; dly1 = 0; out_log.delete(); n_blk = 0;
    src.push_back(32'hA0A0_0001);
    src.push_back(32'hB0B0_0002);
    for (int i = 0; i < 30; i++) begin
      step();
      if (r1_valid && lq0.size() > 0) begin
        check("t2_r1_ready_blocked", DW'(r1_ready), DW'(0));
        n_blk++;
      end
    end
    drain(20);
    check("t2_blocked_cycles", DW'(n_blk >= 3), DW'(1));
    check("t2_out_count", DW'(out_log.size()), DW'(2));
    if (out_log.size() == 2) begin
      check("t2_out_first", out_log[0], 32'hA0A0_0001);
      check("t2_out_second", out_log[1], 32'hB0B0_0002);
    end
    dly0 = 0;

    // Fill the order FIFO with no responses, then free one slot.
    resp_en0 = 1'b0; resp_en1 = 1'b0;
    for (int i = 0; i < 9; i++) src.push_back(32'h3000_0000 + DW'(i));
    repeat (14) step();
    check("t3_outstanding_full", DW'(outstanding), DW'(8));
    check("t3_s_ready_full", DW'(s_ready), DW'(0));
    check("t3_s_valid_waiting", DW'(s_valid), DW'(1));
    resp_en0 = 1'b1;
    step();
    check("t3_r0_fire", DW'(f_r0), DW'(1));
    check("t3_s_ready_still_low", DW'(s_ready), DW'(0));
    step();
    check("t3_outstanding_after_pop", DW'(outstanding), DW'(7));
    check("t3_s_ready_rises", DW'(s_ready), DW'(1));
    resp_en1 = 1'b1;
    drain(100);

    // Toggling out_ready with a continuous response stream.
    out_mode = 1; out_log.delete();
    for (int i = 0; i < 100; i++) src.push_back(DW'($urandom));
    drain(1500);
    check("t5_out_count", DW'(out_log.size()), DW'(100));
    check("t5_scoreboard_empty", DW'(exp_out.size()), DW'(0));
    out_mode = 0;

    // Reset with three words outstanding and a word stalled on the output.
    out_mode = 2;
    for (int i = 0; i < 4; i++) src.push_back(32'h6000_0000 + DW'(i));
    repeat (12) step();
    check("t6_outstanding_pre", DW'(outstanding), DW'(3));
    check("t6_out_valid_pre", DW'(out_valid), DW'(1));
    @(posedge clk);
    #2 apply_reset();

    // Lane 0 stalled: word 0 parks, word 1 goes to lane 1, word 2 waits.
    m0_rdy_en = 1'b0;
    src.push_back(32'hC000_0000);
    src.push_back(32'hC000_0001);
    src.push_back(32'hC000_0002);
    step();
    check("t4_first_accept", DW'(f_s), DW'(1));
    repeat (5) step();
    check("t4_m0_valid_parked", DW'(m0_valid), DW'(1));
    check("t4_m0_data_parked", m0_data, 32'hC000_0000);
    check("t4_s_ready_stalled", DW'(s_ready), DW'(0));
    check("t4_s_data_word2", s_data, 32'hC000_0002);
    check("t4_outstanding", DW'(outstanding), DW'(2));
    check("t4_mlog_count", DW'(m_log.size()), DW'(1));
    if (m_log.size() > 0) begin
      check("t4_word1_lane", DW'(m_log[0].lane), DW'(1));
      check("t4_word1_data", m_log[0].d, 32'hC000_0001);
    end
    m0_rdy_en = 1'b1;
    drain(60);
    check("t4_outstanding_end", DW'(outstanding), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
